// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int INSN_W = 32;

  // Memory is 8-byte word addressed; the low three address bits never reach it.
  localparam logic [ADDR_W-1:0] WORD_ALIGN_MASK = ~64'h7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates CPU fetch and data ports onto one single-port memory, steering read data back.
// Latency: 3 cycles minimum per access (grant, memory wait >= 1, ready pulse), all outputs registered.
// Backpressure: requesters hold until their one-cycle ready; memory stalls by withholding m_ack indefinitely.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [INSN_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              grant_if_q, grant_if_d;   // 1 = fetch owns the in-flight access
  logic              sel_hi_q, sel_hi_d;       // fetch wants upper half of the word
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [INSN_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              fetch_win;

  // State and output registers; reset abandons any in-flight access without a ready pulse.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      grant_if_q <= 1'b0;
      sel_hi_q   <= 1'b0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      grant_if_q <= grant_if_d;
      sel_hi_q   <= sel_hi_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
    end
  end

  // Next-state: grant in IDLE, hold the handshake in BUSY, single ready pulse in RESP.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    grant_if_d = grant_if_q;
    sel_hi_d   = sel_hi_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    fetch_win  = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // Data normally wins a tie; a fetch that has lost STARVE_MAX ties in a row goes first.
          fetch_win  = if_req && (!d_req || (starve_q == STARVE_LIM));
          grant_if_d = fetch_win;
          m_req_d    = 1'b1;
          state_d    = BUSY;
          if (fetch_win) begin
            m_we_d   = 1'b0;
            m_addr_d = if_addr & WORD_ALIGN_MASK;
            sel_hi_d = if_addr[2];
            starve_d = '0;
          end else begin
            m_we_d    = d_we;
            m_addr_d  = d_addr & WORD_ALIGN_MASK;
            m_wdata_d = d_wdata;
            if (if_req && (starve_q != STARVE_LIM)) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end
      BUSY: begin
        if (m_ack) begin
          m_req_d = 1'b0;
          state_d = RESP;
          if (grant_if_q) begin
            if_rdata_d = sel_hi_q ? m_rdata[63:32] : m_rdata[31:0];
            if_ready_d = 1'b1;
          end else begin
            if (!m_we_q) begin
              d_rdata_d = m_rdata;
            end
            d_ready_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word-addressed memory model.
// Latency: memory acks after a programmable number of wait cycles.
// Backpressure: wait_cfg stretches the memory handshake.
module tb_mem_port_arbiter;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] d_rdata;
  logic        d_ready;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic        m_ack;
  logic [63:0] m_rdata;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 CLOCK = ~CLOCK;

  // Memory model: 16 words, preloaded on reset, acks after wait_cfg cycles of m_req.
  logic [63:0] mem [0:15];
  int wait_cfg = 0;
  int wcnt = 0;
  int ack_count = 0;
  int rdy_count = 0;
  int both_count = 0;

  assign m_ack   = m_req && (wcnt == wait_cfg);
  assign m_rdata = mem[m_addr[6:3]];

  always @(posedge CLOCK) begin
    if (!RESET) begin
      wcnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 64'h0;
      mem[0] <= 64'hAAAABBBB_CCCCDDDD;
      mem[2] <= 64'h11223344_55667788;
    end else if (m_req) begin
      if (m_ack) begin
        wcnt <= 0;
        ack_count <= ack_count + 1;
        if (m_we) mem[m_addr[6:3]] <= m_wdata;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  always @(negedge CLOCK) begin
    if (if_ready || d_ready) rdy_count <= rdy_count + 1;
    if (if_ready && d_ready) both_count <= both_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (from a negedge) for a ready pulse; returns cycles elapsed, the port, and m_addr while m_req was up.
  task automatic wait_rdy(output int lat, output logic was_if, output logic [63:0] addr_seen);
    lat = 0;
    was_if = 1'b0;
    addr_seen = '1;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLOCK);
      lat++;
      if (m_req) addr_seen = m_addr;
      if (if_ready || d_ready) begin
        was_if = if_ready;
        return;
      end
    end
    check("ready_timeout", 64'(lat), 64'd0);
  endtask

  int          lat;
  logic        was_if;
  logic [63:0] addr_seen;
  logic [9:0]  order;

  initial begin
    // Reset state
    RESET = 1'b0;
    repeat (2) @(negedge CLOCK);
    check("rst_m_req", 64'(m_req), 64'd0);
    check("rst_m_we", 64'(m_we), 64'd0);
    check("rst_m_addr", m_addr, 64'd0);
    check("rst_m_wdata", m_wdata, 64'd0);
    check("rst_if_rdata", 64'(if_rdata), 64'd0);
    check("rst_d_rdata", d_rdata, 64'd0);
    check("rst_readies", {62'd0, if_ready, d_ready}, 64'd0);
    RESET = 1'b1;
    @(negedge CLOCK);

    // Single load, zero wait
    wait_cfg = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h10;
    @(negedge CLOCK);
    check("load_m_req_c1", 64'(m_req), 64'd1);
    check("load_m_addr", m_addr, 64'h10);
    wait_rdy(lat, was_if, addr_seen);
    d_req = 1'b0;
    check("load_lat", 64'(lat + 1), 64'd2);
    check("load_port_d", 64'(was_if), 64'd0);
    check("load_data", d_rdata, 64'h11223344_55667788);
    @(negedge CLOCK);
    check("ready_one_cycle", {62'd0, if_ready, d_ready}, 64'd0);

    // Fetch word select, upper then lower half
    if_req = 1'b1; if_addr = 64'h4;
    wait_rdy(lat, was_if, addr_seen);
    if_req = 1'b0;
    check("fetch4_lat", 64'(lat), 64'd2);
    check("fetch4_port", 64'(was_if), 64'd1);
    check("fetch4_maddr", addr_seen, 64'h0);
    check("fetch4_data", 64'(if_rdata), 64'hAAAABBBB);
    check("fetch4_d_hold", d_rdata, 64'h11223344_55667788);
    @(negedge CLOCK);
    if_req = 1'b1; if_addr = 64'h0;
    wait_rdy(lat, was_if, addr_seen);
    if_req = 1'b0;
    check("fetch0_maddr", addr_seen, 64'h0);
    check("fetch0_data", 64'(if_rdata), 64'hCCCCDDDD);
    @(negedge CLOCK);
    check("fetch_rdata_held", 64'(if_rdata), 64'hCCCCDDDD);

    // Store then reload with 3 wait cycles
    wait_cfg = 3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h20; d_wdata = 64'hDEADBEEF_00000001;
    wait_rdy(lat, was_if, addr_seen);
    d_req = 1'b0; d_we = 1'b0;
    check("store_lat", 64'(lat), 64'd5);
    check("store_port_d", 64'(was_if), 64'd0);
    check("store_d_rdata_hold", d_rdata, 64'h11223344_55667788);
    check("store_mem", mem[4], 64'hDEADBEEF_00000001);
    @(negedge CLOCK);
    d_req = 1'b1; d_addr = 64'h20;
    wait_rdy(lat, was_if, addr_seen);
    d_req = 1'b0;
    check("reload_lat", 64'(lat), 64'd5);
    check("reload_data", d_rdata, 64'hDEADBEEF_00000001);
    @(negedge CLOCK);

    // Starvation: both held high, expected D,D,D,D,IF,D,D,D,D,IF
    wait_cfg = 0;
    if_req = 1'b1; if_addr = 64'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h10;
    order = '0;
    for (int g = 0; g < 10; g++) begin
      wait_rdy(lat, was_if, addr_seen);
      order[g] = was_if;
      if (g == 0) check("tie_lat", 64'(lat), 64'd2);
      else check($sformatf("b2b_lat_%0d", g), 64'(lat), 64'd3);
    end
    if_req = 1'b0; d_req = 1'b0;
    check("starve_order", 64'(order), 64'(10'b10000_10000));
    check("starve_if_data", 64'(if_rdata), 64'hAAAABBBB);
    @(negedge CLOCK);

    // Reset while BUSY with no ack
    wait_cfg = 1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h10;
    repeat (2) @(negedge CLOCK);
    check("busy_m_req", 64'(m_req), 64'd1);
    RESET = 1'b0;
    @(negedge CLOCK);
    check("mid_rst_m_req", 64'(m_req), 64'd0);
    check("mid_rst_m_addr", m_addr, 64'd0);
    check("mid_rst_if_rdata", 64'(if_rdata), 64'd0);
    check("mid_rst_d_rdata", d_rdata, 64'd0);
    check("mid_rst_readies", {62'd0, if_ready, d_ready}, 64'd0);
    wait_cfg = 0;
    RESET = 1'b1;
    wait_rdy(lat, was_if, addr_seen);
    d_req = 1'b0;
    check("post_rst_lat", 64'(lat), 64'd2);
    check("post_rst_data", d_rdata, 64'h11223344_55667788);

    // Request raised during RESP waits for the following IDLE edge
    @(negedge CLOCK);
    d_req = 1'b1; d_addr = 64'h10;
    wait_rdy(lat, was_if, addr_seen);
    d_req = 1'b0;
    if_req = 1'b1; if_addr = 64'h0;
    @(negedge CLOCK);
    check("resp_req_not_granted", 64'(m_req), 64'd0);
    wait_rdy(lat, was_if, addr_seen);
    if_req = 1'b0;
    check("resp_req_lat", 64'(lat + 1), 64'd3);
    check("resp_req_port", 64'(was_if), 64'd1);
    repeat (2) @(negedge CLOCK);

    check("ready_per_ack", 64'(rdy_count), 64'(ack_count));
    check("never_both_ready", 64'(both_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
